// File: rtl/mem_arbiter_pkg.sv
// Shared types and constants for the two-client memory arbiter.
// No logic of its own: FSM state encoding, port ids and the reset level.
// Imported by mem_arbiter and mem_arb_pick.
package mem_arbiter_pkg;

    typedef enum logic [1:0] {
        ARB_IDLE = 2'd0,
        ARB_BUSY = 2'd1,
        ARB_RESP = 2'd2
    } arb_state_e;

    // Client identifiers: icache is port 0, dcache is port 1
    localparam logic ARB_PORT_I = 1'b0;
    localparam logic ARB_PORT_D = 1'b1;

    // Level of rst that resets the block
    localparam logic RST_ENABLE = 1'b0;

endpackage

// File: rtl/mem_arb_pick.sv
// Grant selector for two requesters; purely combinational, zero latency.
// Tie policy: round robin against last_grant when ARB_ROUND_ROBIN_EN is defined,
// otherwise fixed priority with the dcache (port 1) winning ties.
module mem_arb_pick
    import mem_arbiter_pkg::*;
(
    input  logic req0_i,
    input  logic req1_i,
    input  logic last_grant_i,
    output logic grant_valid_o,
    output logic grant_id_o
);

    // Pick the single requester, or break a tie according to the build option
    always_comb begin
        grant_valid_o = req0_i | req1_i;
        grant_id_o    = ARB_PORT_I;
        if (req0_i && req1_i) begin
`ifdef ARB_ROUND_ROBIN_EN
            grant_id_o = ~last_grant_i;
`else
            grant_id_o = ARB_PORT_D;
`endif
        end else if (req1_i) begin
            grant_id_o = ARB_PORT_D;
        end
    end

`ifndef ARB_ROUND_ROBIN_EN
    // Fixed priority has no use for the grant history
    logic unused_last_grant;
    assign unused_last_grant = last_grant_i;
`endif

endmodule

// File: rtl/mem_arbiter.sv
// Shares one memory port between icache (port 0) and dcache (port 1); tie policy set by ARB_ROUND_ROBIN_EN.
// Latency: mem_req_o one cycle after a sampled request; reply pulse one cycle after mem_ack_i.
// Backpressure: clients hold req until their rep pulse; memory is aborted after TIMEOUT cycles with no ack.
module mem_arbiter
    import mem_arbiter_pkg::*;
#(
    parameter int ADDR_W  = 32,
    parameter int LINE_W  = 64,
    parameter int TIMEOUT = 255
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              c0_req_i,
    input  logic [ADDR_W-1:0] c0_addr_i,
    output logic              c0_rep_o,
    input  logic              c1_req_i,
    input  logic [ADDR_W-1:0] c1_addr_i,
    input  logic              c1_write_i,
    input  logic [31:0]       c1_wdata_i,
    input  logic [3:0]        c1_wmask_i,
    output logic              c1_rep_o,
    output logic [LINE_W-1:0] rep_data_o,
    output logic              mem_req_o,
    output logic [ADDR_W-1:0] mem_addr_o,
    output logic              mem_write_o,
    output logic [31:0]       mem_wdata_o,
    output logic [3:0]        mem_wmask_o,
    input  logic              mem_ack_i,
    input  logic [LINE_W-1:0] mem_rdata_i,
    output logic              err_o
);

    localparam int CNT_W = $clog2(TIMEOUT + 1);

    arb_state_e        state_q;
    logic              owner_q;
    logic              last_grant_q;
    logic [CNT_W-1:0]  cnt_q;
    logic [CNT_W-1:0]  cnt_d;
    logic              c0_rep_q;
    logic              c1_rep_q;
    logic [LINE_W-1:0] rep_data_q;
    logic              mem_req_q;
    logic [ADDR_W-1:0] mem_addr_q;
    logic              mem_write_q;
    logic [31:0]       mem_wdata_q;
    logic [3:0]        mem_wmask_q;
    logic              err_q;

    logic grant_valid;
    logic grant_id;

    mem_arb_pick u_pick (
        .req0_i        (c0_req_i),
        .req1_i        (c1_req_i),
        .last_grant_i  (last_grant_q),
        .grant_valid_o (grant_valid),
        .grant_id_o    (grant_id)
    );

    // Cycles spent in BUSY including the current one
    always_comb begin
        cnt_d = cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
    end

    // Arbiter FSM with registered outputs: grant, wait for ack or timeout, one reply cycle
    always_ff @(posedge clk) begin
        if (rst == RST_ENABLE) begin
            state_q      <= ARB_IDLE;
            owner_q      <= ARB_PORT_I;
            last_grant_q <= ARB_PORT_D;
            cnt_q        <= '0;
            c0_rep_q     <= 1'b0;
            c1_rep_q     <= 1'b0;
            rep_data_q   <= '0;
            mem_req_q    <= 1'b0;
            mem_addr_q   <= '0;
            mem_write_q  <= 1'b0;
            mem_wdata_q  <= '0;
            mem_wmask_q  <= '0;
            err_q        <= 1'b0;
        end else begin
            case (state_q)
                ARB_IDLE: begin
                    if (grant_valid) begin
                        owner_q      <= grant_id;
                        last_grant_q <= grant_id;
                        cnt_q        <= '0;
                        mem_req_q    <= 1'b1;
                        if (grant_id == ARB_PORT_D) begin
                            mem_addr_q  <= c1_addr_i;
                            mem_write_q <= c1_write_i;
                            mem_wdata_q <= c1_wdata_i;
                            mem_wmask_q <= c1_write_i ? c1_wmask_i : 4'b0000;
                        end else begin
                            // icache only ever reads
                            mem_addr_q  <= c0_addr_i;
                            mem_write_q <= 1'b0;
                            mem_wdata_q <= '0;
                            mem_wmask_q <= 4'b0000;
                        end
                        state_q <= ARB_BUSY;
                    end
                end
                ARB_BUSY: begin
                    if (mem_ack_i) begin
                        rep_data_q <= mem_rdata_i;
                        c0_rep_q   <= (owner_q == ARB_PORT_I);
                        c1_rep_q   <= (owner_q == ARB_PORT_D);
                        mem_req_q  <= 1'b0;
                        state_q    <= ARB_RESP;
                    end else if (cnt_d == CNT_W'(TIMEOUT)) begin
                        // Abort: complete the owner with an all-zero line and flag it
                        err_q      <= 1'b1;
                        rep_data_q <= '0;
                        c0_rep_q   <= (owner_q == ARB_PORT_I);
                        c1_rep_q   <= (owner_q == ARB_PORT_D);
                        mem_req_q  <= 1'b0;
                        state_q    <= ARB_RESP;
                    end else begin
                        cnt_q <= cnt_d;
                    end
                end
                ARB_RESP: begin
                    // Owner drops its request this cycle, so no grant is made here
                    c0_rep_q   <= 1'b0;
                    c1_rep_q   <= 1'b0;
                    rep_data_q <= '0;
                    state_q    <= ARB_IDLE;
                end
                default: begin
                    state_q <= ARB_IDLE;
                end
            endcase
        end
    end

    assign c0_rep_o    = c0_rep_q;
    assign c1_rep_o    = c1_rep_q;
    assign rep_data_o  = rep_data_q;
    assign mem_req_o   = mem_req_q;
    assign mem_addr_o  = mem_addr_q;
    assign mem_write_o = mem_write_q;
    assign mem_wdata_o = mem_wdata_q;
    assign mem_wmask_o = mem_wmask_q;
    assign err_o       = err_q;

endmodule
